// File: rtl/xlr8_button_reader_pkg.sv
// ============================================================================
// Module   : xlr8_io_pkg
// Brief    : Shared timing constants and event encodings for board I/O logic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package xlr8_io_pkg;

    localparam int   CLK_HZ        = 16000000;
    localparam int   DEBOUNCE_1MS  = 16000;
    localparam int   LONG_PRESS_1S = 16000000;
    localparam logic EV_RELEASE    = 1'b0;
    localparam logic EV_PRESS      = 1'b1;

    // Channel-index width, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/xlr8_button_reader_if.sv
// ============================================================================
// Module   : xlr8_button_reader_if
// Brief    : One-deep valid/ready button-event channel.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface xlr8_button_reader_if #(
    parameter int IDX_W = 3
);
    logic             event_valid;
    logic             event_ready;
    logic [IDX_W-1:0] event_index;
    logic             event_is_press;

    modport master (output event_valid, output event_index, output event_is_press,
                    input  event_ready);
    modport slave  (input  event_valid, input  event_index, input  event_is_press,
                    output event_ready);
endinterface

`default_nettype wire

// File: rtl/xlr8_button_reader_debounce_channel.sv
// ============================================================================
// Module   : xlr8_debounce_channel
// Brief    : Two-flop synchroniser, debounce counter, press/release pulses and
//            optional hold counter (XLR8_LONG_PRESS_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module xlr8_debounce_channel
    import xlr8_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = DEBOUNCE_1MS,
    parameter bit ACTIVE_LOW        = 1'b1,
    parameter int LONG_PRESS_CYCLES = LONG_PRESS_1S
) (
    input  wire  CLOCK,
    input  wire  RESET,
    input  wire  raw_in,
    output logic level,
    output logic press,
    output logic release_pulse,
    output logic long_press
);
    localparam int               c_CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic             c_INACTIVE = ACTIVE_LOW;

    logic               r_sync1;
    logic               r_sync2;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_level;
    logic               r_press;
    logic               r_release;
    logic               w_s;

    // Normalise the pin to active-high after synchronisation.
    assign w_s = r_sync2 ^ c_INACTIVE;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_sync1   <= c_INACTIVE;
            r_sync2   <= c_INACTIVE;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_sync1   <= raw_in;
            r_sync2   <= r_sync1;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            if (w_s == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_MAX) begin
                r_level   <= w_s;
                r_cnt     <= '0;
                r_press   <= w_s;
                r_release <= ~w_s;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign level         = r_level;
    assign press         = r_press;
    assign release_pulse = r_release;

`ifdef XLR8_LONG_PRESS_EN
    localparam int                  c_HOLD_W   = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_MAX = c_HOLD_W'(LONG_PRESS_CYCLES);

    logic [c_HOLD_W-1:0] r_hold;
    logic                r_long;

    // Saturates at the threshold so the pulse fires once per hold.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_hold <= '0;
            r_long <= 1'b0;
        end else begin
            r_long <= 1'b0;
            if (!r_level) begin
                r_hold <= '0;
            end else if (r_hold != c_HOLD_MAX) begin
                r_hold <= r_hold + 1'b1;
                r_long <= (r_hold == c_HOLD_MAX - 1'b1);
            end
        end
    end

    assign long_press = r_long;
`else
    localparam bit c_LONG_EN = (LONG_PRESS_CYCLES < 0);
    assign long_press = c_LONG_EN;
`endif

endmodule

`default_nettype wire

// File: rtl/xlr8_button_reader.sv
// ============================================================================
// Module   : xlr8_button_reader
// Brief    : Debounced button inputs with press/release pulses, a one-deep
//            event register and sticky overflow. Long-press: XLR8_LONG_PRESS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module xlr8_button_reader
    import xlr8_io_pkg::*;
#(
    parameter int N_INPUTS          = 6,
    parameter int DEBOUNCE_CYCLES   = DEBOUNCE_1MS,
    parameter bit ACTIVE_LOW        = 1'b1,
    parameter int LONG_PRESS_CYCLES = LONG_PRESS_1S
) (
    input  wire                 CLOCK,
    input  wire                 RESET,
    input  wire  [N_INPUTS-1:0] raw_in,
    output logic [N_INPUTS-1:0] level,
    output logic [N_INPUTS-1:0] press,
    output logic [N_INPUTS-1:0] release_pulse,
    output logic [N_INPUTS-1:0] long_press,
    output logic                overflow,
    input  wire                 overflow_clear,
    xlr8_button_reader_if.master ev
);
    localparam int c_IDX_W = idx_width(N_INPUTS);

    logic [N_INPUTS-1:0] w_edge;
    logic [c_IDX_W-1:0]  w_idx;
    logic                w_any;
    logic                w_multi;
    logic                w_load;
    logic                w_drop;
    logic                r_valid;
    logic [c_IDX_W-1:0]  r_idx;
    logic                r_is_press;
    logic                r_overflow;

    genvar gi;
    generate
        for (gi = 0; gi < N_INPUTS; gi++) begin : g_ch
            xlr8_debounce_channel #(
                .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
                .ACTIVE_LOW       (ACTIVE_LOW),
                .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
            ) u_ch (
                .CLOCK        (CLOCK),
                .RESET        (RESET),
                .raw_in       (raw_in[gi]),
                .level        (level[gi]),
                .press        (press[gi]),
                .release_pulse(release_pulse[gi]),
                .long_press   (long_press[gi])
            );
        end
    endgenerate

    assign w_edge = press | release_pulse;

    // Lowest-index pulsing channel wins; scan high to low so it is written last.
    always_comb begin
        w_idx = '0;
        for (int i = N_INPUTS - 1; i >= 0; i--) begin
            if (w_edge[i]) begin
                w_idx = c_IDX_W'(i);
            end
        end
    end

    assign w_any   = |w_edge;
    assign w_multi = |(w_edge & (w_edge - 1'b1));
    assign w_load  = w_any && (!r_valid || ev.event_ready);
    assign w_drop  = (w_any && !w_load) || (w_load && w_multi);

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_valid    <= 1'b0;
            r_idx      <= '0;
            r_is_press <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_load) begin
                r_valid    <= 1'b1;
                r_idx      <= w_idx;
                r_is_press <= press[w_idx] ? EV_PRESS : EV_RELEASE;
            end else if (ev.event_ready) begin
                r_valid <= 1'b0;
            end
            // A drop in the same cycle as a clear keeps the flag set.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (overflow_clear) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign ev.event_valid    = r_valid;
    assign ev.event_index    = r_idx;
    assign ev.event_is_press = r_is_press;
    assign overflow          = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_xlr8_button_reader.sv
// ============================================================================
// Module   : tb_xlr8_button_reader
// Brief    : Directed self-checking bench for xlr8_button_reader
//            (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, ACTIVE_LOW=1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_xlr8_button_reader;

    localparam int c_N   = 6;
    localparam int c_DB  = 4;
    localparam int c_LP  = 20;
    localparam int c_LAT = c_DB + 2;

    logic           CLOCK = 1'b0;
    logic           RESET = 1'b1;
    logic [c_N-1:0] raw_in = '1;
    logic [c_N-1:0] level;
    logic [c_N-1:0] press;
    logic [c_N-1:0] release_pulse;
    logic [c_N-1:0] long_press;
    logic           overflow;
    logic           overflow_clear = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    xlr8_button_reader_if #(.IDX_W(3)) ev ();

    xlr8_button_reader #(
        .N_INPUTS         (c_N),
        .DEBOUNCE_CYCLES  (c_DB),
        .ACTIVE_LOW       (1'b1),
        .LONG_PRESS_CYCLES(c_LP)
    ) dut (
        .CLOCK         (CLOCK),
        .RESET         (RESET),
        .raw_in        (raw_in),
        .level         (level),
        .press         (press),
        .release_pulse (release_pulse),
        .long_press    (long_press),
        .overflow      (overflow),
        .overflow_clear(overflow_clear),
        .ev            (ev.master)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    int long_cnt;
    int long_at;
    int press0_cnt;

    initial begin
        ev.event_ready = 1'b0;

        // Reset state and idle after release
        repeat (3) tick();
        chk("rst_level", level, 0);
        chk("rst_valid", ev.event_valid, 0);
        chk("rst_ovf", overflow, 0);
        RESET = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            chk("idle_level", level, 0);
            chk("idle_pulse", press | release_pulse, 0);
            chk("idle_valid", ev.event_valid, 0);
        end

        // Channel 2 press: level/press after 6 clocks, event next cycle
        raw_in[2] = 1'b0;
        ev.event_ready = 1'b1;
        for (int i = 1; i <= c_LAT; i++) begin
            tick();
            if (i == c_LAT - 1) chk("ch2_early", level, 0);
        end
        chk("ch2_level", level, 6'b000100);
        chk("ch2_press", press, 6'b000100);
        tick();
        chk("ch2_valid", ev.event_valid, 1);
        chk("ch2_index", ev.event_index, 2);
        chk("ch2_is_press", ev.event_is_press, 1);
        chk("ch2_press_gone", press, 0);
        tick();
        chk("ch2_consumed", ev.event_valid, 0);

        // Channel 0 bounces; only the final stable low is accepted
        press0_cnt = 0;
        for (int b = 0; b < 4; b++) begin
            raw_in[0] = (b % 2 == 0) ? 1'b0 : 1'b1;
            repeat (2) begin
                tick();
                if (press[0]) press0_cnt++;
                chk("bounce_level0", level[0], 0);
            end
        end
        raw_in[0] = 1'b0;
        for (int i = 1; i <= c_LAT; i++) begin
            tick();
            if (press[0]) press0_cnt++;
            if (i == c_LAT - 1) chk("bounce_early", level[0], 0);
        end
        chk("bounce_press0", press[0], 1);
        repeat (3) begin
            tick();
            if (press[0]) press0_cnt++;
        end
        chk("bounce_single", press0_cnt, 1);
        chk("bounce_idle", ev.event_valid, 0);

        // Channels 1 and 4 together with consumer stalled
        ev.event_ready = 1'b0;
        raw_in[1] = 1'b0;
        raw_in[4] = 1'b0;
        repeat (c_LAT) tick();
        chk("dual_press", press, 6'b010010);
        tick();
        chk("dual_valid", ev.event_valid, 1);
        chk("dual_index", ev.event_index, 1);
        chk("dual_ovf", overflow, 1);
        repeat (3) tick();
        chk("dual_hold_idx", ev.event_index, 1);
        chk("dual_hold_valid", ev.event_valid, 1);
        overflow_clear = 1'b1;
        tick();
        overflow_clear = 1'b0;
        chk("ovf_cleared", overflow, 0);
        chk("ovf_clr_valid", ev.event_valid, 1);

        // Reset in the middle of a channel-3 bounce
        raw_in = 6'b110111;
        repeat (2) tick();
        RESET = 1'b1;
        #1;
        chk("mid_rst_level", level, 0);
        chk("mid_rst_valid", ev.event_valid, 0);
        chk("mid_rst_ovf", overflow, 0);
        repeat (3) begin
            tick();
            chk("mid_rst_pulse", press | release_pulse, 0);
        end
        RESET = 1'b0;
        for (int i = 1; i <= c_LAT; i++) begin
            tick();
            if (i == c_LAT - 1) chk("post_rst_early", level, 0);
        end
        chk("post_rst_press", press, 6'b001000);
        tick();
        chk("post_rst_index", ev.event_index, 3);
        chk("post_rst_valid", ev.event_valid, 1);

        // Release of channel 3 while the event is stalled is dropped
        raw_in[3] = 1'b1;
        repeat (c_LAT) tick();
        chk("rel3_pulse", release_pulse, 6'b001000);
        chk("rel3_level", level, 0);
        tick();
        chk("stall_ovf", overflow, 1);
        chk("stall_index", ev.event_index, 3);
        chk("stall_is_press", ev.event_is_press, 1);

        // Channel 5 held 40 cycles past its press
        ev.event_ready = 1'b1;
        raw_in[5] = 1'b0;
        repeat (c_LAT) tick();
        chk("ch5_press", press, 6'b100000);
        long_cnt = 0;
        long_at  = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (long_press != 0) begin
                long_cnt++;
                long_at = i;
                chk("long_chan", long_press, 6'b100000);
            end
        end
`ifdef XLR8_LONG_PRESS_EN
        chk("long_count", long_cnt, 1);
        chk("long_time", long_at, c_LP);
`else
        chk("long_count", long_cnt, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/xlr8_button_reader.md
Name: xlr8_button_reader

Overview:
- Input-side counterpart of the board's LED/counter output logic.
- Samples up to N raw Arduino header pins (A5..A0 by default), synchronises and debounces each one.
- Emits per-channel level and one-cycle press/release pulses.
- Serialises edges into a one-deep valid/ready event register for downstream control logic.

Parameters:
- N_INPUTS, 6: number of input channels (1..16).
- DEBOUNCE_CYCLES, 16000: consecutive stable cycles needed to accept a change (1 ms at 16 MHz); minimum 1.
- ACTIVE_LOW, 1: 1 means a pin reads 0 when pressed (pull-up wiring); inputs are normalised to active-high internally.
- LONG_PRESS_CYCLES, 16000000: hold time for the long-press pulse (1 s); used only with XLR8_LONG_PRESS_EN.

Ports:
- CLOCK  in  1  16 MHz system clock.
- RESET  in  1  asynchronous, active-high reset.
- raw_in  in  N_INPUTS  unsynchronised pin levels.
- level  out  N_INPUTS  debounced level, active-high (1 = pressed).
- press  out  N_INPUTS  one-cycle pulse when a channel's level goes 0->1.
- release  out  N_INPUTS  one-cycle pulse when a channel's level goes 1->0.
- event_valid  out  1  event register holds an event.
- event_ready  in  1  consumer accepts the event.
- event_index  out  $clog2(N_INPUTS) (min 1)  channel of the held event.
- event_is_press  out  1  1 = press, 0 = release.
- overflow  out  1  sticky flag: an edge event was dropped.
- overflow_clear  in  1  clears overflow.
- long_press  out  N_INPUTS  one-cycle long-hold pulse; constant 0 without the macro.

Behaviour:
- Reset values: all outputs 0. Sync flops reset to the inactive pin level (ACTIVE_LOW). Counters reset to 0.
- Synchroniser: two flops per channel. s[i] = sync2[i] XOR ACTIVE_LOW.
- Debounce, per channel:
  - If s[i] == level[i]: cnt <= 0.
  - Otherwise cnt increments. When cnt == DEBOUNCE_CYCLES-1: level <= s, cnt <= 0, and press or release is asserted in the same cycle level changes.
  - Any return to the old level before the threshold resets cnt; no glitch reaches level.
- Latency: a clean raw transition appears on level exactly DEBOUNCE_CYCLES+2 clocks later.
- Counter width: $clog2(DEBOUNCE_CYCLES+1). The counter never wraps.
- Event register: a handshake completes when event_valid && event_ready.
  - Load condition: some press/release pulse is present AND (!event_valid OR event_ready). The lowest-index pulsing channel is loaded. event_valid stays 1 on a back-to-back load.
  - With event_ready high and no pulse: event_valid <= 0.
  - event_index and event_is_press are held stable while valid && !ready.
- Drops set overflow:
  - An edge that is not loaded because of a lower-index simultaneous edge.
  - An edge arriving while event_valid && !event_ready.
  - overflow_clear clears overflow next cycle. If a drop occurs in the same cycle, set wins.
- Reset mid-bounce: all counters and pending events are discarded. A pin still held after RESET falls reports press DEBOUNCE_CYCLES+2 clocks later.

Optional Feature:
- Macro: XLR8_LONG_PRESS_EN.
- Defined:
  - Per-channel hold counter of width $clog2(LONG_PRESS_CYCLES+1). It clears when level=0 and counts while level=1.
  - long_press[i] pulses once when level has been 1 for LONG_PRESS_CYCLES cycles counted from the press pulse; it saturates and does not repeat until release.
  - Long presses are not entered in the event register.
- Undefined: no hold counters are synthesised; long_press is tied to 0.

Decomposition:
- Package xlr8_io_pkg holds: CLK_HZ = 16000000, DEBOUNCE_1MS = 16000, LONG_PRESS_1S = 16000000, EV_RELEASE = 0, EV_PRESS = 1.
- One natural sub-module, xlr8_debounce_channel: synchroniser, debounce counter, level, press/release, and the optional hold counter. It is instantiated N_INPUTS times by a generate loop.
- The top level contains the priority encoder, event register and overflow logic.

Test Plan (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, ACTIVE_LOW=1):
- Reset release with all raw_in=1 -> level=0, no pulses, event_valid=0 for 50 cycles.
- raw_in[2] 1->0 held, event_ready=1 -> level[2]=1 and press[2] exactly 6 cycles later. Next cycle: event_valid=1, event_index=2, event_is_press=1.
- raw_in[0] bounces 0,1,0,1 with 2-cycle spacing, then stable 0 -> single press[0], 6 cycles after the last transition; no earlier level change.
- Channels 1 and 4 press in the same cycle, event_ready=0 -> event_index=1 is held; overflow=1. Pulse overflow_clear -> overflow=0.
- Assert RESET during a bounce on channel 3 with raw_in[3]=0 held -> all outputs 0 during reset; press[3] 6 cycles after RESET deasserts.
- XLR8_LONG_PRESS_EN, channel 5 held 40 cycles -> one long_press[5] pulse 20 cycles after press[5]. Without the macro, long_press stays 0.
